// File: rtl/io_timer_periph.sv
// Memory-mapped LED/switch/timer peripheral: eight 16-bit registers behind a
// simple select/read-write bus, a prescaled compare timer and a level interrupt.
module io_timer_periph #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        mem1_ena,
    input  logic        d_rw,
    input  logic [2:0]  addr,
    input  logic [15:0] mem1_dout,
    output logic [15:0] mem1_din,
    input  logic [15:0] sw_i,
    output logic [15:0] led_o,
    output logic        irq_o
);

    typedef enum logic [2:0] {
        REG_LED    = 3'd0,
        REG_SW     = 3'd1,
        REG_CTRL   = 3'd2,
        REG_PRESC  = 3'd3,
        REG_COUNT  = 3'd4,
        REG_CMP    = 3'd5,
        REG_STATUS = 3'd6,
        REG_RSVD   = 3'd7
    } reg_addr_e;

    reg_addr_e   reg_sel;
    logic        wr_en, rd_en;
    logic        wr_led, wr_ctrl, wr_presc, wr_count, wr_cmp, wr_status;
    logic        tick, match_hit;
    logic [15:0] rd_mux;

    logic [15:0] sw_sync [SYNC_STAGES];
    logic [15:0] led_q, presc_q, count_q, cmp_q, presc_cnt;
    logic        ctrl_en, ctrl_ar, ctrl_ien, match_q;

    assign reg_sel   = reg_addr_e'(addr);
    assign wr_en     = mem1_ena & d_rw;
    assign rd_en     = mem1_ena & ~d_rw;
    assign wr_led    = wr_en && (reg_sel == REG_LED);
    assign wr_ctrl   = wr_en && (reg_sel == REG_CTRL);
    assign wr_presc  = wr_en && (reg_sel == REG_PRESC);
    assign wr_count  = wr_en && (reg_sel == REG_COUNT);
    assign wr_cmp    = wr_en && (reg_sel == REG_CMP);
    assign wr_status = wr_en && (reg_sel == REG_STATUS);

    // A bus write to COUNT overrides the timer on that edge, so the tick is dropped.
    assign tick      = ctrl_en && (presc_cnt == presc_q) && !wr_count;
    assign match_hit = tick && (count_q == cmp_q);

    assign led_o = led_q;
    assign irq_o = match_q & ctrl_ien;

    // NOTE: every flop here is reset, including the synchronizer, so sw reads 0 after reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) sw_sync[i] <= '0;
        end else begin
            sw_sync[0] <= sw_i;
            for (int i = 1; i < SYNC_STAGES; i++) sw_sync[i] <= sw_sync[i-1];
        end
    end

    // NOTE: always_comb with a default on every path so no latch is inferred.
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_LED:    rd_mux = led_q;
            REG_SW:     rd_mux = sw_sync[SYNC_STAGES-1];
            REG_CTRL:   rd_mux = {13'd0, ctrl_ien, ctrl_ar, ctrl_en};
            REG_PRESC:  rd_mux = presc_q;
            REG_COUNT:  rd_mux = count_q;
            REG_CMP:    rd_mux = cmp_q;
            REG_STATUS: rd_mux = {15'd0, match_q};
            default:    rd_mux = '0;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            led_q     <= '0;
            presc_q   <= '0;
            count_q   <= '0;
            cmp_q     <= '0;
            presc_cnt <= '0;
            ctrl_en   <= 1'b0;
            ctrl_ar   <= 1'b0;
            ctrl_ien  <= 1'b0;
            match_q   <= 1'b0;
            mem1_din  <= '0;
        end else begin
            if (wr_led)   led_q   <= mem1_dout;
            if (wr_presc) presc_q <= mem1_dout;
            if (wr_cmp)   cmp_q   <= mem1_dout;

            if (wr_ctrl) begin
                ctrl_en  <= mem1_dout[0];
                ctrl_ar  <= mem1_dout[1];
                ctrl_ien <= mem1_dout[2];
            end else if (match_hit && !ctrl_ar) begin
                ctrl_en  <= 1'b0;
            end

            if (wr_count)                 count_q <= mem1_dout;
            else if (match_hit && ctrl_ar) count_q <= '0;
            else if (tick && !match_hit)   count_q <= count_q + 16'd1;

            // Hardware set beats a coincident write-1-to-clear.
            if (match_hit)                       match_q <= 1'b1;
            else if (wr_status && mem1_dout[0])  match_q <= 1'b0;

            if (!ctrl_en || wr_presc || wr_count || tick) presc_cnt <= '0;
            else                                          presc_cnt <= presc_cnt + 16'd1;

            if (rd_en) mem1_din <= rd_mux;
        end
    end

endmodule

// File: tb/tb_io_timer_periph.sv
// Directed bench for io_timer_periph: bus reads are scored against a queue of
// expected values pushed when the read is issued.
module tb_io_timer_periph;

    localparam int SYNC_STAGES = 2;

    localparam logic [2:0] A_LED = 3'd0, A_SW = 3'd1, A_CTRL = 3'd2, A_PRESC = 3'd3,
                           A_COUNT = 3'd4, A_CMP = 3'd5, A_STATUS = 3'd6, A_RSVD = 3'd7;

    logic        CLK, RESET_N;
    logic        mem1_ena, d_rw;
    logic [2:0]  addr;
    logic [15:0] mem1_dout, mem1_din, sw_i, led_o;
    logic        irq_o;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q [$];
    string       tag_q [$];

    io_timer_periph #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .mem1_ena (mem1_ena),
        .d_rw     (d_rw),
        .addr     (addr),
        .mem1_dout(mem1_dout),
        .mem1_din (mem1_din),
        .sw_i     (sw_i),
        .led_o    (led_o),
        .irq_o    (irq_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Tasks start and end on a falling edge; each consumes exactly one rising edge.
    task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
        mem1_ena = 1'b1; d_rw = 1'b1; addr = a; mem1_dout = d;
        @(negedge CLK);
        mem1_ena = 1'b0; d_rw = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
        logic [15:0] e;
        string t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        mem1_ena = 1'b1; d_rw = 1'b0; addr = a;
        @(negedge CLK);
        mem1_ena = 1'b0;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, mem1_din, e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0; mem1_ena = 1'b0; d_rw = 1'b0; addr = '0; mem1_dout = '0; sw_i = '0;
        #2;
        check("rst_led", led_o, 16'h0);
        check("rst_irq", {15'd0, irq_o}, 16'h0);
        check("rst_din", mem1_din, 16'h0);
        idle(2);
        RESET_N = 1'b1;

        // First access right after release; all registers read 0.
        for (int i = 0; i < 8; i++) bus_rd(3'(i), 16'h0, $sformatf("rst_reg%0d", i));

        // LED write/read, read data holds while idle and during writes.
        bus_wr(A_LED, 16'hA5A5);
        check("led_after_wr", led_o, 16'hA5A5);
        bus_rd(A_LED, 16'hA5A5, "rd_led");
        idle(3);
        check("din_hold_idle", mem1_din, 16'hA5A5);
        bus_wr(A_LED, 16'h0F0F);
        check("din_hold_wr", mem1_din, 16'hA5A5);
        check("led_o_0f0f", led_o, 16'h0F0F);

        // RO / reserved writes ignored, CTRL upper bits read 0.
        bus_wr(A_SW, 16'hFFFF);
        bus_wr(A_RSVD, 16'hFFFF);
        bus_rd(A_RSVD, 16'h0, "rsvd_rd");
        bus_rd(A_SW, 16'h0, "sw_ro");
        bus_wr(A_CTRL, 16'hFFF8);
        bus_rd(A_CTRL, 16'h0, "ctrl_upper");

        // Switch synchronizer latency.
        sw_i = 16'h1234;
        idle(SYNC_STAGES);
        bus_rd(A_SW, 16'h1234, "sw_1234");
        idle(4);
        check("sw_hold", mem1_din, 16'h1234);
        sw_i = 16'hBEEF;
        bus_rd(A_SW, 16'h1234, "sw_lat0");
        bus_rd(A_SW, 16'h1234, "sw_lat1");
        bus_rd(A_SW, 16'hBEEF, "sw_lat2");

        // Prescaled auto-reload timer with interrupt.
        bus_wr(A_PRESC, 16'd3);
        bus_wr(A_CMP, 16'd2);
        bus_wr(A_COUNT, 16'd0);
        bus_wr(A_CTRL, 16'h0007);
        idle(4);
        bus_rd(A_COUNT, 16'd1, "ar_count1");
        idle(3);
        bus_rd(A_COUNT, 16'd2, "ar_count2");
        check("ar_irq_pre", {15'd0, irq_o}, 16'h0);
        idle(3);
        check("ar_irq", {15'd0, irq_o}, 16'h1);
        bus_rd(A_STATUS, 16'h1, "ar_match");
        bus_rd(A_COUNT, 16'd0, "ar_reload");
        bus_rd(A_STATUS, 16'h1, "rd_no_side_effect");
        bus_wr(A_STATUS, 16'h0001);
        check("w1c_irq", {15'd0, irq_o}, 16'h0);
        bus_wr(A_CTRL, 16'h0000);

        // One-shot, PRESC=0, interrupt disabled.
        bus_wr(A_STATUS, 16'h0001);
        bus_wr(A_PRESC, 16'd0);
        bus_wr(A_CMP, 16'd1);
        bus_wr(A_COUNT, 16'd0);
        bus_wr(A_CTRL, 16'h0001);
        idle(1);
        bus_rd(A_COUNT, 16'd1, "os_count1");
        bus_rd(A_CTRL, 16'h0, "os_en_clr");
        bus_rd(A_COUNT, 16'd1, "os_hold");
        bus_rd(A_STATUS, 16'h1, "os_match");
        check("os_irq_off", {15'd0, irq_o}, 16'h0);
        bus_wr(A_CTRL, 16'h0004);
        check("os_irq_ien", {15'd0, irq_o}, 16'h1);
        bus_wr(A_STATUS, 16'h0001);
        check("os_irq_clr", {15'd0, irq_o}, 16'h0);

        // Wrap without a flag, then W1C coincident with a match.
        bus_wr(A_CTRL, 16'h0000);
        bus_wr(A_CMP, 16'h0005);
        bus_wr(A_COUNT, 16'hFFFF);
        bus_wr(A_CTRL, 16'h0001);
        idle(1);
        bus_rd(A_COUNT, 16'h0000, "wrap_count");
        bus_rd(A_STATUS, 16'h0, "wrap_nomatch");
        bus_wr(A_CTRL, 16'h0000);
        bus_wr(A_CMP, 16'd7);
        bus_wr(A_COUNT, 16'd7);
        bus_wr(A_CTRL, 16'h0003);
        bus_wr(A_STATUS, 16'h0001);
        bus_rd(A_STATUS, 16'h1, "set_beats_w1c");
        bus_rd(A_COUNT, 16'd1, "w1c_reload_run");
        bus_wr(A_CTRL, 16'h0000);
        bus_wr(A_STATUS, 16'h0001);

        // Bus write to COUNT wins over a coincident tick.
        bus_wr(A_CMP, 16'h8000);
        bus_wr(A_CTRL, 16'h0001);
        bus_wr(A_COUNT, 16'h0100);
        bus_rd(A_COUNT, 16'h0100, "count_wr_wins");
        bus_rd(A_COUNT, 16'h0101, "count_after_wr");

        // Writing PRESC restarts the prescaler.
        bus_wr(A_CTRL, 16'h0000);
        bus_wr(A_PRESC, 16'd3);
        bus_wr(A_COUNT, 16'd0);
        bus_wr(A_CTRL, 16'h0001);
        idle(2);
        bus_wr(A_PRESC, 16'd3);
        idle(1);
        bus_rd(A_COUNT, 16'd0, "presc_restart");
        idle(2);
        bus_rd(A_COUNT, 16'd1, "presc_tick");

        // CTRL write wins over a coincident one-shot EN clear.
        bus_wr(A_CTRL, 16'h0000);
        bus_wr(A_PRESC, 16'd0);
        bus_wr(A_CMP, 16'd3);
        bus_wr(A_COUNT, 16'd3);
        bus_wr(A_CTRL, 16'h0001);
        bus_wr(A_CTRL, 16'h0005);
        bus_rd(A_CTRL, 16'h0005, "ctrl_wr_wins");
        check("ctrl_wins_irq", {15'd0, irq_o}, 16'h1);

        // Asynchronous reset in the middle of a running timer.
        bus_wr(A_CTRL, 16'h0000);
        bus_wr(A_STATUS, 16'h0001);
        sw_i = 16'h0000;
        bus_wr(A_LED, 16'h5A5A);
        bus_wr(A_PRESC, 16'd1);
        bus_wr(A_CMP, 16'd2);
        bus_wr(A_COUNT, 16'd2);
        bus_wr(A_CTRL, 16'h0007);
        idle(3);
        check("pre_rst_irq", {15'd0, irq_o}, 16'h1);
        bus_rd(A_LED, 16'h5A5A, "pre_rst_din");
        #2;
        RESET_N = 1'b0;
        #1;
        check("async_led", led_o, 16'h0);
        check("async_irq", {15'd0, irq_o}, 16'h0);
        check("async_din", mem1_din, 16'h0);
        idle(2);
        RESET_N = 1'b1;
        for (int i = 0; i < 8; i++) bus_rd(3'(i), 16'h0, $sformatf("post_rst_reg%0d", i));
        idle(6);
        bus_rd(A_COUNT, 16'h0, "post_rst_idle");
        bus_rd(A_STATUS, 16'h0, "post_rst_nomatch");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
